vga_timing_gen: RTL



---
 rtl/vga_timing_gen.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised raster timing generator. A clock divider produces a one-clock
// pixel strobe; horizontal and vertical counters run on that strobe and give
// the current pixel coordinates. Sync and display-enable are decoded from the
// counters, registered, then delayed by PIPE_DELAY further strobes so they line
// up with a pipelined colour mapper. Line/frame markers stay undelayed and are
// aligned with draw_x/draw_y.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high
//   pix_en       one-clock pixel strobe (forced low while reset is high)
//   draw_x       current horizontal count, 0..H_TOTAL-1
//   draw_y       current vertical count, 0..V_TOTAL-1
//   hs, vs       horizontal / vertical sync, active level HS_POL / VS_POL
//   blank        display enable: 1 = active video, 0 = blanking
//   sync         composite sync for the DAC, tied to 0
//   line_start   pix_en cycle with draw_x == 0
//   frame_start  pix_en cycle with draw_x == 0 and draw_y == 0
//   frame_count  completed frames, wraps modulo 2^16
// -----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int   H_ACTIVE   = 640,
    parameter int   H_FRONT    = 16,
    parameter int   H_SYNC     = 96,
    parameter int   H_BACK     = 48,
    parameter int   V_ACTIVE   = 480,
    parameter int   V_FRONT    = 10,
    parameter int   V_SYNC     = 2,
    parameter int   V_BACK     = 33,
    parameter int   CLK_DIV    = 2,
    parameter logic HS_POL     = 1'b0,
    parameter logic VS_POL     = 1'b0,
    parameter int   PIPE_DELAY = 0,
    parameter int   COORD_W    = 10
) (
    input  logic               clk,
    input  logic               reset,
    output logic               pix_en,
    output logic [COORD_W-1:0] draw_x,
    output logic [COORD_W-1:0] draw_y,
    output logic               hs,
    output logic               vs,
    output logic               blank,
    output logic               sync,
    output logic               line_start,
    output logic               frame_start,
    output logic [15:0]        frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CW1     = COORD_W + 1;

    if (CLK_DIV < 1) begin : g_chk_div
        $error("vga_timing_gen: CLK_DIV must be >= 1");
    end
    if (PIPE_DELAY < 0 || PIPE_DELAY > 7) begin : g_chk_pipe
        $error("vga_timing_gen: PIPE_DELAY must be in 0..7");
    end
    if (longint'(H_TOTAL - 1) >= (longint'(1) << COORD_W)) begin : g_chk_h
        $error("vga_timing_gen: H_TOTAL-1 does not fit in COORD_W bits");
    end
    if (longint'(V_TOTAL - 1) >= (longint'(1) << COORD_W)) begin : g_chk_v
        $error("vga_timing_gen: V_TOTAL-1 does not fit in COORD_W bits");
    end

    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);

    // Window bounds are one bit wider so the sync end may equal 2^COORD_W.
    localparam logic [CW1-1:0] H_ACT_END = CW1'(H_ACTIVE);
    localparam logic [CW1-1:0] HS_START  = CW1'(H_ACTIVE + H_FRONT);
    localparam logic [CW1-1:0] HS_END    = CW1'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [CW1-1:0] V_ACT_END = CW1'(V_ACTIVE);
    localparam logic [CW1-1:0] VS_START  = CW1'(V_ACTIVE + V_FRONT);
    localparam logic [CW1-1:0] VS_END    = CW1'(V_ACTIVE + V_FRONT + V_SYNC);

    // Timing flags in "active" sense; polarity is applied only at the outputs.
    typedef struct packed {
        logic hs;
        logic vs;
        logic en;
    } timing_t;

    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [COORD_W-1:0] h_cnt_q, h_cnt_d;
    logic [COORD_W-1:0] v_cnt_q, v_cnt_d;
    logic [15:0]        frame_count_q, frame_count_d;
    logic               strobe;
    logic [CW1-1:0]     h_ext, v_ext;
    timing_t            stage_d;
    // Index 0 holds the registered raw decode, 1..PIPE_DELAY the extra delay.
    timing_t            pipe_q [PIPE_DELAY+1];

    assign strobe = (div_cnt_q == DIV_LAST);
    assign h_ext  = {1'b0, h_cnt_q};
    assign v_ext  = {1'b0, v_cnt_q};

    // NOTE: every variable gets its hold value first, so no path through this
    // block leaves a signal unassigned and no latch is inferred.
    always_comb begin
        div_cnt_d     = strobe ? '0 : div_cnt_q + 1'b1;
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        frame_count_d = frame_count_q;
        if (strobe) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                if (v_cnt_q == V_LAST) begin
                    v_cnt_d       = '0;
                    frame_count_d = frame_count_q + 16'd1;
                end else begin
                    v_cnt_d = v_cnt_q + 1'b1;
                end
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end

        stage_d.hs = (h_ext >= HS_START) && (h_ext < HS_END);
        stage_d.vs = (v_ext >= VS_START) && (v_ext < VS_END);
        stage_d.en = (h_ext < H_ACT_END) && (v_ext < V_ACT_END);
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q     <= '0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            frame_count_q <= '0;
            // NOTE: the delay line is a handful of flops, not a RAM, so it is
            // cleared here; otherwise stale sync would leak out after reset.
            for (int i = 0; i <= PIPE_DELAY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            div_cnt_q     <= div_cnt_d;
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            frame_count_q <= frame_count_d;
            if (strobe) begin
                pipe_q[0] <= stage_d;
                for (int i = 1; i <= PIPE_DELAY; i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
        end
    end

    assign pix_en      = strobe && !reset;
    assign draw_x      = h_cnt_q;
    assign draw_y      = v_cnt_q;
    assign frame_count = frame_count_q;
    assign hs          = pipe_q[PIPE_DELAY].hs ? HS_POL : ~HS_POL;
    assign vs          = pipe_q[PIPE_DELAY].vs ? VS_POL : ~VS_POL;
    assign blank       = pipe_q[PIPE_DELAY].en;
    assign sync        = 1'b0;
    assign line_start  = pix_en && (h_cnt_q == '0);
    assign frame_start = line_start && (v_cnt_q == '0);

endmodule
